// File: rtl/axi_write_scheduler.sv
// Write-channel scheduler: arbitrates AW between M1/M2, decodes S0-S5 or default slave, gates AW/W/B for one transaction.
// Latency: AW request in IDLE -> AWVALID_S next cycle; minimum 4 cycles per transaction (IDLE, ADDR, DATA, RESP).
// Backpressure: handshakes pass straight through between granted master and selected slave; the other master sees ready/valid 0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   AWVALID/AWADDR/AWREADY_Mx     master address channel (x = 1 CPU, 2 DMA)
//   WVALID/WLAST/WREADY_Mx        master write-data channel
//   BVALID/BREADY_Mx              master response channel
//   AWVALID_S/AWREADY_S ...       per-slave handshakes, bit n = Sn
//   grant, slave_sel              registered steering for the payload muxes
//   BRESP_DS                      default-slave response (DECERR)
module axi_write_scheduler #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              AWVALID_M1,
    input  logic              AWVALID_M2,
    input  logic [ADDR_W-1:0] AWADDR_M1,
    input  logic [ADDR_W-1:0] AWADDR_M2,
    output logic              AWREADY_M1,
    output logic              AWREADY_M2,
    input  logic              WVALID_M1,
    input  logic              WVALID_M2,
    input  logic              WLAST_M1,
    input  logic              WLAST_M2,
    output logic              WREADY_M1,
    output logic              WREADY_M2,
    output logic              BVALID_M1,
    output logic              BVALID_M2,
    input  logic              BREADY_M1,
    input  logic              BREADY_M2,
    output logic [5:0]        AWVALID_S,
    input  logic [5:0]        AWREADY_S,
    output logic [5:0]        WVALID_S,
    input  logic [5:0]        WREADY_S,
    input  logic [5:0]        BVALID_S,
    output logic [5:0]        BREADY_S,
    output logic [1:0]        grant,
    output logic [2:0]        slave_sel,
    output logic [1:0]        BRESP_DS
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [2:0] SEL_DEFAULT = 3'd6;
    localparam logic [2:0] SEL_NONE    = 3'd7;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_grant;
    logic [1:0]  r_last_grant;
    logic [2:0]  r_slave_sel;
    logic [7:0]  r_beat_cnt;

    logic [1:0]  w_req;
    logic [1:0]  w_grant_pick;
    logic [ADDR_W-1:0] w_pick_addr;
    logic [2:0]  w_pick_sel;

    logic        w_awvalid_g;
    logic        w_wvalid_g;
    logic        w_wlast_g;
    logic        w_bready_g;
    logic        w_awready_g;
    logic        w_wready_g;
    logic        w_bvalid_g;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_b_hs;
    logic [5:0]  w_onehot;
    logic        w_is_ds;

    // Inclusive ranges; S3 deliberately includes 0x1002_0400 itself.
    function automatic logic [2:0] f_decode(input logic [ADDR_W-1:0] a);
        logic [31:0] x;
        x = 32'(a);
        if (x <= 32'h0000_3FFF)                              return 3'd0;
        else if (x >= 32'h0001_0000 && x <= 32'h0001_FFFF)   return 3'd1;
        else if (x >= 32'h0002_0000 && x <= 32'h0002_FFFF)   return 3'd2;
        else if (x >= 32'h1002_0000 && x <= 32'h1002_0400)   return 3'd3;
        else if (x >= 32'h1001_0000 && x <= 32'h1001_03FF)   return 3'd4;
        else if (x >= 32'h2000_0000 && x <= 32'h201F_FFFF)   return 3'd5;
        else                                                 return SEL_DEFAULT;
    endfunction

    // Round-robin pick: a tie goes to the master that was not served last.
    assign w_req = {AWVALID_M2, AWVALID_M1};

    always_comb begin
        w_grant_pick = 2'b00;
        case (w_req)
            2'b01:   w_grant_pick = 2'b01;
            2'b10:   w_grant_pick = 2'b10;
            2'b11:   w_grant_pick = (r_last_grant == 2'b01) ? 2'b10 : 2'b01;
            default: w_grant_pick = 2'b00;
        endcase
    end

    assign w_pick_addr = w_grant_pick[1] ? AWADDR_M2 : AWADDR_M1;
    assign w_pick_sel  = f_decode(w_pick_addr);

    // Granted-master views of the master-side inputs.
    assign w_awvalid_g = (r_grant[0] & AWVALID_M1) | (r_grant[1] & AWVALID_M2);
    assign w_wvalid_g  = (r_grant[0] & WVALID_M1)  | (r_grant[1] & WVALID_M2);
    assign w_wlast_g   = (r_grant[0] & WLAST_M1)   | (r_grant[1] & WLAST_M2);
    assign w_bready_g  = (r_grant[0] & BREADY_M1)  | (r_grant[1] & BREADY_M2);

    // Slave steering only from registered selection; 6 and 7 select no slave bit.
    assign w_onehot = (r_slave_sel < SEL_DEFAULT) ? (6'd1 << r_slave_sel) : 6'd0;
    assign w_is_ds  = (r_slave_sel == SEL_DEFAULT);

    assign w_aw_hs = w_awvalid_g & w_awready_g;
    assign w_w_hs  = w_wvalid_g & w_wready_g;
    assign w_b_hs  = w_bvalid_g & w_bready_g;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (|w_req)                 w_next_state = ST_ADDR;
            ST_ADDR: if (w_aw_hs)                w_next_state = ST_DATA;
            ST_DATA: if (w_w_hs && w_wlast_g)    w_next_state = ST_RESP;
            ST_RESP: if (w_b_hs)                 w_next_state = ST_IDLE;
            default:                             w_next_state = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        AWVALID_S   = 6'd0;
        WVALID_S    = 6'd0;
        BREADY_S    = 6'd0;
        w_awready_g = 1'b0;
        w_wready_g  = 1'b0;
        w_bvalid_g  = 1'b0;
        case (r_state)
            ST_ADDR: begin
                AWVALID_S   = w_onehot;
                w_awready_g = w_is_ds | (|(AWREADY_S & w_onehot));
            end
            ST_DATA: begin
                WVALID_S   = w_onehot & {6{w_wvalid_g}};
                w_wready_g = w_is_ds | (|(WREADY_S & w_onehot));
            end
            ST_RESP: begin
                BREADY_S   = w_onehot & {6{w_bready_g}};
                w_bvalid_g = w_is_ds | (|(BVALID_S & w_onehot));
            end
            default: ;
        endcase
    end

    assign AWREADY_M1 = w_awready_g & r_grant[0];
    assign AWREADY_M2 = w_awready_g & r_grant[1];
    assign WREADY_M1  = w_wready_g  & r_grant[0];
    assign WREADY_M2  = w_wready_g  & r_grant[1];
    assign BVALID_M1  = w_bvalid_g  & r_grant[0];
    assign BVALID_M2  = w_bvalid_g  & r_grant[1];

    assign grant     = r_grant;
    assign slave_sel = r_slave_sel;
    assign BRESP_DS  = 2'b11;

    // Grant, selection and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= 2'b00;
            r_last_grant <= 2'b10;
            r_slave_sel  <= SEL_NONE;
            r_beat_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_grant     <= w_grant_pick;
                        r_slave_sel <= w_pick_sel;
                    end
                end
                ST_ADDR: begin
                    if (w_aw_hs) r_beat_cnt <= 8'd0;
                end
                ST_DATA: begin
                    if (w_w_hs && r_beat_cnt != 8'hFF) r_beat_cnt <= r_beat_cnt + 8'd1;
                end
                ST_RESP: begin
                    if (w_b_hs) begin
                        r_last_grant <= r_grant;
                        r_grant      <= 2'b00;
                        r_slave_sel  <= SEL_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_scheduler.sv
// Directed bench for axi_write_scheduler: drives inputs on the falling edge, checks 1 ns later.
// Latency: expected values are hand-derived per cycle from the transaction tables below.
// Backpressure: slave WREADY and master BREADY stalls are injected by run_txn arguments.
module tb_axi_write_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        AWVALID_M1 = 1'b0, AWVALID_M2 = 1'b0;
    logic [31:0] AWADDR_M1 = 32'd0, AWADDR_M2 = 32'd0;
    logic        AWREADY_M1, AWREADY_M2;
    logic        WVALID_M1 = 1'b0, WVALID_M2 = 1'b0;
    logic        WLAST_M1 = 1'b0, WLAST_M2 = 1'b0;
    logic        WREADY_M1, WREADY_M2;
    logic        BVALID_M1, BVALID_M2;
    logic        BREADY_M1 = 1'b0, BREADY_M2 = 1'b0;
    logic [5:0]  AWVALID_S;
    logic [5:0]  AWREADY_S = 6'h3F;
    logic [5:0]  WVALID_S;
    logic [5:0]  WREADY_S = 6'h3F;
    logic [5:0]  BVALID_S = 6'h00;
    logic [5:0]  BREADY_S;
    logic [1:0]  grant;
    logic [2:0]  slave_sel;
    logic [1:0]  BRESP_DS;

    int n_checks = 0;
    int n_pass   = 0;

    axi_write_scheduler #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .AWVALID_M1(AWVALID_M1), .AWVALID_M2(AWVALID_M2),
        .AWADDR_M1(AWADDR_M1), .AWADDR_M2(AWADDR_M2),
        .AWREADY_M1(AWREADY_M1), .AWREADY_M2(AWREADY_M2),
        .WVALID_M1(WVALID_M1), .WVALID_M2(WVALID_M2),
        .WLAST_M1(WLAST_M1), .WLAST_M2(WLAST_M2),
        .WREADY_M1(WREADY_M1), .WREADY_M2(WREADY_M2),
        .BVALID_M1(BVALID_M1), .BVALID_M2(BVALID_M2),
        .BREADY_M1(BREADY_M1), .BREADY_M2(BREADY_M2),
        .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
        .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
        .grant(grant), .slave_sel(slave_sel), .BRESP_DS(BRESP_DS)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    task automatic set_aw(input int m, input logic v, input logic [31:0] a);
        if (m == 1) begin AWVALID_M1 = v; AWADDR_M1 = a; end
        else        begin AWVALID_M2 = v; AWADDR_M2 = a; end
    endtask

    task automatic set_w(input int m, input logic v, input logic l);
        if (m == 1) begin WVALID_M1 = v; WLAST_M1 = l; end
        else        begin WVALID_M2 = v; WLAST_M2 = l; end
    endtask

    task automatic set_b(input int m, input logic r);
        if (m == 1) BREADY_M1 = r;
        else        BREADY_M2 = r;
    endtask

    function automatic logic awready_of(input int m);
        return (m == 1) ? AWREADY_M1 : AWREADY_M2;
    endfunction
    function automatic logic wready_of(input int m);
        return (m == 1) ? WREADY_M1 : WREADY_M2;
    endfunction
    function automatic logic bvalid_of(input int m);
        return (m == 1) ? BVALID_M1 : BVALID_M2;
    endfunction

    // Called at a falling edge while the block is IDLE. Runs one full write from master m.
    task automatic run_txn(input int m, input logic [31:0] addr, input int beats,
                           input logic [2:0] esel, input int wst, input int bst, input bit early);
        logic [5:0] oh;
        logic [1:0] eg;
        eg = (m == 1) ? 2'b01 : 2'b10;
        oh = 6'd0;
        if (esel < 3'd6) oh[esel] = 1'b1;
        set_aw(m, 1'b1, addr);
        // ADDR
        @(negedge clk); #1;
        check("grant", {30'd0, grant}, {30'd0, eg});
        check("slave_sel", {29'd0, slave_sel}, {29'd0, esel});
        check("awvalid_s", {26'd0, AWVALID_S}, {26'd0, oh});
        check("awready_m", {31'd0, awready_of(m)}, 32'd1);
        check("awready_other", {31'd0, awready_of(3 - m)}, 32'd0);
        // DATA
        @(negedge clk);
        set_aw(m, 1'b0, addr);
        for (int b = 0; b < beats; b++) begin
            set_w(m, 1'b1, (b == beats - 1));
            BVALID_S = early ? oh : 6'd0;
            if (b == 0) begin
                for (int s = 0; s < wst; s++) begin
                    WREADY_S = 6'd0;
                    #1;
                    check("wstall_wready", {31'd0, wready_of(m)}, 32'd0);
                    check("wstall_wvalid_s", {26'd0, WVALID_S}, {26'd0, oh});
                    @(negedge clk);
                end
            end
            WREADY_S = 6'h3F;
            #1;
            check("wready_m", {31'd0, wready_of(m)}, 32'd1);
            check("wvalid_s", {26'd0, WVALID_S}, {26'd0, oh});
            check("bvalid_in_data", {31'd0, bvalid_of(m)}, 32'd0);
            check("wready_other", {31'd0, wready_of(3 - m)}, 32'd0);
            @(negedge clk);
        end
        // RESP
        set_w(m, 1'b0, 1'b0);
        BVALID_S = oh;
        #1;
        check("beat_cnt", {24'd0, dut.r_beat_cnt}, beats);
        for (int s = 0; s < bst; s++) begin
            set_b(m, 1'b0);
            #1;
            check("bstall_bvalid", {31'd0, bvalid_of(m)}, 32'd1);
            check("bstall_bready_s", {26'd0, BREADY_S}, 32'd0);
            @(negedge clk);
        end
        set_b(m, 1'b1);
        #1;
        check("bvalid_m", {31'd0, bvalid_of(m)}, 32'd1);
        check("bready_s", {26'd0, BREADY_S}, {26'd0, oh});
        check("bvalid_other", {31'd0, bvalid_of(3 - m)}, 32'd0);
        // back in IDLE
        @(negedge clk);
        set_b(m, 1'b0);
        BVALID_S = 6'd0;
        #1;
        check("idle_grant", {30'd0, grant}, 32'd0);
        check("idle_sel", {29'd0, slave_sel}, 32'd7);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_sel", {29'd0, slave_sel}, 32'd7);
        check("rst_awvalid_s", {26'd0, AWVALID_S}, 32'd0);
        check("rst_awready_m1", {31'd0, AWREADY_M1}, 32'd0);
        check("rst_bresp_ds", {30'd0, BRESP_DS}, 32'd3);

        // Basic write: M1 -> S2, 4 beats
        run_txn(1, 32'h0002_0010, 4, 3'd2, 0, 0, 1'b0);

        // Unmapped: M2 -> default slave, 2 beats (last_grant becomes M2)
        run_txn(2, 32'h3000_0000, 2, 3'd6, 0, 0, 1'b0);
        check("bresp_ds", {30'd0, BRESP_DS}, 32'd3);

        // Simultaneous requests to S5, twice: M1, M2, M1, M2
        for (int r = 0; r < 2; r++) begin
            set_aw(2, 1'b1, 32'h2000_0000);
            run_txn(1, 32'h2000_0000, 1, 3'd5, 0, 0, 1'b0);
            run_txn(2, 32'h2000_0000, 1, 3'd5, 0, 0, 1'b0);
        end

        // Backpressure on S4: WREADY low 3 cycles, BREADY low 2 cycles
        run_txn(1, 32'h1001_0000, 2, 3'd4, 3, 2, 1'b0);

        // Early slave response from S1 during DATA
        run_txn(1, 32'h0001_0040, 2, 3'd1, 0, 0, 1'b1);

        // Decode boundaries, lone requester M2
        run_txn(2, 32'h1002_0400, 1, 3'd3, 0, 0, 1'b0);
        run_txn(2, 32'h1002_0404, 1, 3'd6, 0, 0, 1'b0);
        run_txn(2, 32'h0000_4000, 1, 3'd6, 0, 0, 1'b0);
        run_txn(2, 32'h201F_FFFF, 1, 3'd5, 0, 0, 1'b0);

        // Reset in DATA after one of four beats
        set_aw(1, 1'b1, 32'h0000_0100);
        @(negedge clk); #1;
        check("rm_grant", {30'd0, grant}, 32'd1);
        @(negedge clk);
        set_aw(1, 1'b0, 32'h0000_0100);
        set_w(1, 1'b1, 1'b0);
        #1;
        check("rm_wready", {31'd0, WREADY_M1}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_w(1, 1'b0, 1'b0);
        #1;
        check("rm_grant0", {30'd0, grant}, 32'd0);
        check("rm_sel7", {29'd0, slave_sel}, 32'd7);
        check("rm_awvalid_s", {26'd0, AWVALID_S}, 32'd0);
        check("rm_wvalid_s", {26'd0, WVALID_S}, 32'd0);
        check("rm_bready_s", {26'd0, BREADY_S}, 32'd0);
        check("rm_wready_m1", {31'd0, WREADY_M1}, 32'd0);
        check("rm_bvalid_m1", {31'd0, BVALID_M1}, 32'd0);
        run_txn(1, 32'h0000_3FFC, 1, 3'd0, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
